// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 UART receiver with a valid/read byte handshake.
// The rx line is synchronised and edge-detected. The start bit is checked at mid-bit.
// Each data bit and the stop bit are then sampled one bit period apart.
// A low stop bit raises a one-cycle frame_err pulse. The receiver then waits for the
// line to return high before it looks for the next start edge.
module rs232_rx #(
    parameter int unsigned BAUD_DIV0 = 5208,
    parameter int unsigned BAUD_DIV1 = 2604,
    parameter int unsigned BAUD_DIV2 = 1302
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_setting,
    input  logic       rx,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] div_q, div_d;
    logic [15:0] div_sel;
    logic [15:0] limit;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        tick;

    // Bit period selected by baud_setting; settings 2 and 3 share the fastest rate.
    always_comb begin
        div_sel = 16'(BAUD_DIV2);
        case (baud_setting)
            2'b00:   div_sel = 16'(BAUD_DIV0);
            2'b01:   div_sel = 16'(BAUD_DIV1);
            default: div_sel = 16'(BAUD_DIV2);
        endcase
    end

    // The START state counts half a bit so that later samples land mid-bit.
    assign limit = (state_q == S_START) ? {1'b0, div_q[15:1]} : div_q;
    assign tick  = (baud_cnt_q == limit - 16'd1);

    // Next-state, datapath and handshake logic.
    // Handshake: rx_valid=1 means rx_data holds an unread byte. A cycle with rx_rd=1 and
    // rx_valid=1 consumes that byte, so rx_valid and overrun clear on the next edge.
    // A byte that loads in the same cycle takes priority and keeps rx_valid high.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (rx_rd && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 4'd0;
                if (rx_prev_q && !rx_s_q) begin
                    div_d   = div_sel;
                    state_d = S_START;
                end
            end
            S_START: begin
                baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (tick) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (tick) begin
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rx_rd) begin
                            overrun_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                baud_cnt_d = 16'd0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. The synchroniser and history flops reset low so
    // that a line held low through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b0;
            rx_s_q      <= 1'b0;
            rx_prev_q   <= 1'b0;
            div_q       <= 16'(BAUD_DIV0);
            baud_cnt_q  <= 16'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            div_q       <= div_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
